// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and
// the operand width limits.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  // Counter width for a WIDTH-bit operand; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the shared bit-0 datapath of the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ C;
  assign carry = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: shifts operands LSB-first through one full_adder,
// keeps the carry in a flop between bits and reports {cout,sum} with a done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_s_sr;
  logic             r_carry;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s_bit;
  logic             w_c_out;
  logic [WIDTH-1:0] w_s_ext;

  full_adder u_fa (
    .A     (r_a_sr[0]),
    .B     (r_b_sr[0]),
    .C     (r_carry),
    .sum   (w_s_bit),
    .carry (w_c_out)
  );

  // New sum bit enters at the top; after WIDTH steps the LSB has reached bit 0.
  assign w_s_ext = {w_s_bit, r_s_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_bitcnt == LAST_BIT) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_s_sr   <= '0;
      r_carry  <= 1'b0;
      r_bitcnt <= '0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_carry  <= cin;
      r_bitcnt <= '0;
    end else if (w_step) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= w_s_ext[WIDTH-1:1];
      r_carry <= w_c_out;
      // Counter holds on the last bit so it never wraps inside RUN.
      if (!w_finish) begin
        r_bitcnt <= r_bitcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_finish) begin
      r_sum  <= w_s_ext;
      r_cout <= w_c_out;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl (WIDTH=8): directed adds, ignored restarts,
// mid-run reset and a 1000-vector back-to-back random run against a result queue.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0] exp_q[$];
  int         n_cmp;
  int         n_err;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("queue_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("result", {cout, sum}, exp_q.pop_front());
    end
  end

  // mode 0: plain add; 1: re-pulse start and toggle operands mid-run; 2: reset at bit 4
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int mode);
    int e;
    int busy_cnt;
    bit got;
    logic [W:0] ex;
    ex = model_add(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    if (mode != 2) exp_q.push_back(ex);
    @(posedge clk);
    #1 start = 1'b0;
    e = 0; busy_cnt = 0; got = 0;
    while (e < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) busy_cnt++;
      if (mode == 1 && e == 3) begin
        start = 1'b1; a = ~ta; b = ~tb; cin = ~tc;
      end
      if (mode == 1 && e == 5) start = 1'b0;
      if (mode == 2 && e == 4) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      e++;
    end
    check("done_seen", got, 1);
    check("done_latency", e, W);
    check("busy_cycles", busy_cnt, W);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("sum_hold", {cout, sum}, ex);
    @(negedge clk);
    check("no_restart", busy, 0);
    check("sum_idle", {cout, sum}, ex);
  endtask

  initial begin
    int n_done;
    int cyc;
    int last_done;
    n_cmp = 0; n_err = 0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    rst_n = 1'b1;

    run_add(8'h00, 8'h00, 1'b0, 0);
    run_add(8'hFF, 8'h01, 1'b0, 0);
    run_add(8'hA5, 8'h5A, 1'b1, 0);
    run_add(8'h3C, 8'h0F, 1'b0, 0);
    check("directed_value", {cout, sum}, 9'h04B);
    run_add(8'h12, 8'h34, 1'b0, 1);
    run_add(8'h77, 8'h66, 1'b1, 2);
    run_add(8'h81, 8'h7F, 1'b1, 0);
    check("post_reset_value", {cout, sum}, 9'h101);

    // start held high: every IDLE cycle gets fresh operands
    n_done = 0; cyc = 0; last_done = -1;
    while (n_done < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last_done >= 0) check("spacing", cyc - last_done, W + 2);
        last_done = cyc;
        n_done++;
      end else if (!busy) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1));
        start = 1'b1;
        exp_q.push_back(model_add(a, b, cin));
      end
    end
    start = 1'b0;
    check("random_done_count", n_done, 1000);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
